// File: rtl/ama_riscv_writeback.sv
// ama_riscv_writeback
//   Writeback stage of the AMA-RISCV RV32I pipeline. Registers the EX/MEM
//   result, aligns and extends load data from the synchronous data memory,
//   selects the final writeback value and drives the register file write
//   port plus an identical forwarding bus. Also keeps the retired-instruction
//   counter.
//
// Ports
//   clk, rst                     core clock, async active-high reset
//   ex_valid/ex_reg_we/ex_rd     instruction valid, writes rd, destination
//   ex_wb_sel                    0=ALU, 1=load, 2=PC+4, 3=CSR
//   ex_alu_out/ex_pc/ex_csr_data ALU result (load address), PC, CSR read value
//   ex_funct3                    load width/sign
//   stall, flush                 hold WB register / kill incoming instruction
//   dmem_rdata                   synchronous dmem read word (valid in WB cycle)
//   rf_we/rf_addr_d/rf_data_d    register file write port
//   fwd_valid/fwd_rd/fwd_data    forwarding bus, mirrors the write port
//   instret                      retired-instruction count
module ama_riscv_writeback #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_reg_we,
  input  logic [4:0]           ex_rd,
  input  logic [1:0]           ex_wb_sel,
  input  logic [31:0]          ex_alu_out,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_csr_data,
  input  logic [2:0]           ex_funct3,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          dmem_rdata,
  output logic                 rf_we,
  output logic [4:0]           rf_addr_d,
  output logic [31:0]          rf_data_d,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [31:0]          fwd_data,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_CSR  = 2'd3;

  logic                 r_wb_valid;
  logic                 r_reg_we;
  logic [4:0]           r_rd;
  logic [1:0]           r_wb_sel;
  logic [31:0]          r_alu_out;
  logic [31:0]          r_pc;
  logic [31:0]          r_csr_data;
  logic [2:0]           r_funct3;
  logic                 r_ld_held;
  logic [31:0]          r_ld_data_q;
  logic [INSTRET_W-1:0] r_instret;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_extract;
  logic [31:0] w_ld_data;
  logic [31:0] w_wb_data;
  logic        w_rf_we;

  // dmem_rdata is only valid in the first WB cycle, so a stalled load keeps
  // its extracted value in r_ld_data_q for the rest of the stall.
  always_comb begin
    w_byte       = dmem_rdata[{r_alu_out[1:0], 3'b000} +: 8];
    w_half       = r_alu_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ld_extract = 32'h0;
    case (r_funct3)
      3'b000:  w_ld_extract = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_extract = {24'h0, w_byte};
      3'b001:  w_ld_extract = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_extract = {16'h0, w_half};
      3'b010:  w_ld_extract = dmem_rdata;
      default: w_ld_extract = 32'h0;
    endcase
  end

  assign w_ld_data = r_ld_held ? r_ld_data_q : w_ld_extract;

  always_comb begin
    w_wb_data = r_alu_out;
    case (r_wb_sel)
      WB_ALU:  w_wb_data = r_alu_out;
      WB_LOAD: w_wb_data = w_ld_data;
      WB_PC4:  w_wb_data = r_pc + 32'd4;
      WB_CSR:  w_wb_data = r_csr_data;
      default: w_wb_data = r_alu_out;
    endcase
  end

  assign w_rf_we = r_wb_valid & r_reg_we & (r_rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid  <= 1'b0;
      r_reg_we    <= 1'b0;
      r_rd        <= 5'd0;
      r_wb_sel    <= 2'd0;
      r_alu_out   <= 32'h0;
      r_pc        <= 32'h0;
      r_csr_data  <= 32'h0;
      r_funct3    <= 3'd0;
      r_ld_held   <= 1'b0;
      r_ld_data_q <= 32'h0;
      r_instret   <= '0;
    end else begin
      if (!stall) begin
        r_wb_valid <= ex_valid & ~flush;
        r_reg_we   <= ex_reg_we;
        r_rd       <= ex_rd;
        r_wb_sel   <= ex_wb_sel;
        r_alu_out  <= ex_alu_out;
        r_pc       <= ex_pc;
        r_csr_data <= ex_csr_data;
        r_funct3   <= ex_funct3;
        r_ld_held  <= 1'b0;
      end else if (r_wb_valid && (r_wb_sel == WB_LOAD) && !r_ld_held) begin
        r_ld_held   <= 1'b1;
        r_ld_data_q <= w_ld_extract;
      end

      if (r_wb_valid && !stall)
        r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign rf_we     = w_rf_we;
  assign rf_addr_d = r_rd;
  assign rf_data_d = w_wb_data;
  assign fwd_valid = w_rf_we;
  assign fwd_rd    = r_rd;
  assign fwd_data  = w_wb_data;
  assign instret   = r_instret;

endmodule

// File: tb/tb_ama_riscv_writeback.sv
module tb_ama_riscv_writeback;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_reg_we;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_pc;
  logic [31:0] ex_csr_data;
  logic [2:0]  ex_funct3;
  logic        stall;
  logic        flush;
  logic [31:0] dmem_rdata;

  logic        rf_we, fwd_valid;
  logic [4:0]  rf_addr_d, fwd_rd;
  logic [31:0] rf_data_d, fwd_data;
  logic [63:0] instret;

  // Narrow-counter copy driven identically, used to observe counter wrap.
  logic        w2_rf_we, w2_fwd_valid;
  logic [4:0]  w2_rf_addr_d, w2_fwd_rd;
  logic [31:0] w2_rf_data_d, w2_fwd_data;
  logic [1:0]  w2_instret;

  ama_riscv_writeback #(.INSTRET_W(64)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_reg_we(ex_reg_we),
    .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel), .ex_alu_out(ex_alu_out),
    .ex_pc(ex_pc), .ex_csr_data(ex_csr_data), .ex_funct3(ex_funct3),
    .stall(stall), .flush(flush), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret)
  );

  ama_riscv_writeback #(.INSTRET_W(2)) u_wrap (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_reg_we(ex_reg_we),
    .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel), .ex_alu_out(ex_alu_out),
    .ex_pc(ex_pc), .ex_csr_data(ex_csr_data), .ex_funct3(ex_funct3),
    .stall(stall), .flush(flush), .dmem_rdata(dmem_rdata),
    .rf_we(w2_rf_we), .rf_addr_d(w2_rf_addr_d), .rf_data_d(w2_rf_data_d),
    .fwd_valid(w2_fwd_valid), .fwd_rd(w2_fwd_rd), .fwd_data(w2_fwd_data),
    .instret(w2_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic        we;
    logic        ad;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [63:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] expv, input int t);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, t, act, expv);
  endtask

  // Monitor: compares whatever the DUT presents on the cycle an entry is due.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      e = exp_q.pop_front();
      n_chk++;
      $display("FAIL missed_check tag %0d: got cycle %0d expected cycle %0d", e.tag, cyc, e.tag);
    end
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      e = exp_q.pop_front();
      cmp("rf_we",       {63'b0, rf_we},        {63'b0, e.we}, cyc);
      cmp("fwd_valid",   {63'b0, fwd_valid},    {63'b0, e.we}, cyc);
      cmp("w2_rf_we",    {63'b0, w2_rf_we},     {63'b0, e.we}, cyc);
      cmp("instret",     instret,               e.ir, cyc);
      cmp("instret_w2",  {62'b0, w2_instret},   {62'b0, e.ir[1:0]}, cyc);
      if (e.ad) begin
        cmp("rf_addr_d",    {59'b0, rf_addr_d},    {59'b0, e.addr}, cyc);
        cmp("fwd_rd",       {59'b0, fwd_rd},       {59'b0, e.addr}, cyc);
        cmp("w2_rf_addr_d", {59'b0, w2_rf_addr_d}, {59'b0, e.addr}, cyc);
        cmp("w2_fwd_rd",    {59'b0, w2_fwd_rd},    {59'b0, e.addr}, cyc);
        cmp("rf_data_d",    {32'b0, rf_data_d},    {32'b0, e.data}, cyc);
        cmp("fwd_data",     {32'b0, fwd_data},     {32'b0, e.data}, cyc);
        cmp("w2_rf_data_d", {32'b0, w2_rf_data_d}, {32'b0, e.data}, cyc);
        cmp("w2_fwd_data",  {32'b0, w2_fwd_data},  {32'b0, e.data}, cyc);
      end
    end
  end

  task automatic chk(input int tag, input logic we, input logic ad, input logic [4:0] addr,
                     input logic [31:0] data, input logic [63:0] ir);
    exp_t e;
    e.tag = tag; e.we = we; e.ad = ad; e.addr = addr; e.data = data; e.ir = ir;
    exp_q.push_back(e);
  endtask

  // Drives the next instruction (captured at the following edge) and the
  // dmem word for the instruction currently in WB.
  task automatic drv(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] csr,
                     input logic [2:0] f3, input logic st, input logic fl, input logic [31:0] dm);
    @(posedge clk); #1;
    ex_valid = v; ex_reg_we = we; ex_rd = rd; ex_wb_sel = sel; ex_alu_out = alu;
    ex_pc = pc; ex_csr_data = csr; ex_funct3 = f3; stall = st; flush = fl; dmem_rdata = dm;
  endtask

  task automatic idle(input logic [31:0] dm);
    drv(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, dm);
  endtask

  logic [63:0] exp_ir;
  int          c0;

  logic [2:0]  ld_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
  logic [31:0] ld_off [6] = '{32'd2, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
  logic [31:0] ld_exp [6] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01, 32'h0000_0000};

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_reg_we = 0; ex_rd = 0; ex_wb_sel = 0; ex_alu_out = 0;
    ex_pc = 0; ex_csr_data = 0; ex_funct3 = 0; stall = 0; flush = 0; dmem_rdata = 0;
    exp_ir = 0;

    // reset state
    @(posedge clk); #1;
    chk(cyc, 1'b0, 1'b1, 5'd0, 32'h0, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op
    drv(1, 1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0);
    chk(cyc + 1, 1'b1, 1'b1, 5'd5, 32'h1234_5678, exp_ir); exp_ir++;
    idle(32'h0);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir);

    // back-to-back loads
    for (int i = 0; i < 6; i++) begin
      drv(1, 1, 5'(6 + i), 2'd1, ld_off[i], 32'h0, 32'h0, ld_f3[i], 0, 0, 32'h80FF_7F01);
      chk(cyc + 1, 1'b1, 1'b1, 5'(6 + i), ld_exp[i], exp_ir); exp_ir++;
    end
    idle(32'h80FF_7F01);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir);

    // LBU stalled 3 cycles; dmem word only valid on the first WB cycle
    drv(1, 1, 5'd12, 2'd1, 32'h0, 32'h0, 32'h0, 3'b100, 0, 0, 32'h0);
    c0 = cyc;
    for (int i = 1; i <= 4; i++) chk(c0 + i, 1'b1, 1'b1, 5'd12, 32'h55, exp_ir);
    exp_ir++;
    chk(c0 + 5, 1'b1, 1'b1, 5'd13, 32'h13, exp_ir); exp_ir++;
    drv(1, 1, 5'd13, 2'd0, 32'h13, 32'h0, 32'h0, 3'd0, 1, 0, 32'hAAAA_0055);
    drv(1, 1, 5'd13, 2'd0, 32'h13, 32'h0, 32'h0, 3'd0, 1, 0, 32'h0);
    drv(1, 1, 5'd13, 2'd0, 32'h13, 32'h0, 32'h0, 3'd0, 1, 0, 32'h0);
    drv(1, 1, 5'd13, 2'd0, 32'h13, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0);

    // PC+4 wrap, x0 write, CSR, no-rd-write
    drv(1, 1, 5'd14, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0, 0, 0, 32'h0);
    chk(cyc + 1, 1'b1, 1'b1, 5'd14, 32'h0, exp_ir); exp_ir++;
    drv(1, 1, 5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir); exp_ir++;
    drv(1, 1, 5'd15, 2'd3, 32'h1, 32'h0, 32'h00C0_FFEE, 3'd0, 0, 0, 32'h0);
    chk(cyc + 1, 1'b1, 1'b1, 5'd15, 32'h00C0_FFEE, exp_ir); exp_ir++;
    drv(1, 0, 5'd16, 2'd0, 32'h16, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir); exp_ir++;
    idle(32'h0);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir);

    // flush without stall kills the incoming instruction
    drv(1, 1, 5'd17, 2'd0, 32'h17, 32'h0, 32'h0, 3'd0, 0, 1, 32'h0);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir);
    idle(32'h0);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir);

    // flush under stall leaves the WB instruction in place
    drv(1, 1, 5'd18, 2'd0, 32'h18, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0);
    c0 = cyc;
    chk(c0 + 1, 1'b1, 1'b1, 5'd18, 32'h18, exp_ir);
    chk(c0 + 2, 1'b1, 1'b1, 5'd18, 32'h18, exp_ir);
    exp_ir++;
    chk(c0 + 3, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir);
    drv(1, 1, 5'd19, 2'd0, 32'h19, 32'h0, 32'h0, 3'd0, 1, 1, 32'h0);
    drv(1, 1, 5'd19, 2'd0, 32'h19, 32'h0, 32'h0, 3'd0, 0, 1, 32'h0);
    idle(32'h0);

    // async reset in the middle of a stall
    drv(1, 1, 5'd20, 2'd0, 32'h20, 32'h0, 32'h0, 3'd0, 0, 0, 32'h0);
    chk(cyc + 1, 1'b1, 1'b1, 5'd20, 32'h20, exp_ir);
    drv(1, 1, 5'd21, 2'd0, 32'h21, 32'h0, 32'h0, 3'd0, 1, 0, 32'h0);
    @(posedge clk); #3;
    rst = 1'b1;
    exp_ir = 0;
    chk(cyc, 1'b0, 1'b1, 5'd0, 32'h0, exp_ir);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(32'h0);
    chk(cyc + 1, 1'b0, 1'b1, 5'd0, 32'h0, exp_ir);

    // retire five: narrow counter wraps 3 -> 0 -> 1
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 5'(22 + i), 2'd0, 32'(100 + i), 32'h0, 32'h0, 3'd0, 0, 0, 32'h0);
      chk(cyc + 1, 1'b1, 1'b1, 5'(22 + i), 32'(100 + i), exp_ir); exp_ir++;
    end
    idle(32'h0);
    chk(cyc + 1, 1'b0, 1'b0, 5'd0, 32'h0, exp_ir);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      $display("FAIL timeout tag %0d: got pending expected drained", e.tag);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
